pll_clkdiv: RTL and testbench

- Synthesizable digital stand-in for the vendor PLL wrapper: derives three divided clocks from `clkin1` and reports lock.
- Each output has its own divide ratio, high time and phase offset, all counted in `clkin1` cycles.
- `pll_lock` asserts once a fixed settle count has elapsed after reset release, and stays high until the next reset.
- Sits at the clock-generation root; downstream logic treats `pll_lock` as "clocks valid".

---
 rtl/pll_clkdiv.sv | 133 +++++++++++++
 tb/tb_pll_clkdiv.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pll_clkdiv.sv
// pll_clkdiv: synthesizable PLL stand-in producing three divided clocks of clkin1 plus a sticky lock flag.
// Optional `PLL_CLKOUT_GATE_EN adds per-output gate inputs applied on period boundaries.

module pll_clkdiv_chan #(
  parameter int DIV   = 2,
  parameter int HIGH  = 1,
  parameter int PHASE = 0
) (
  input  logic clkin1,
  input  logic rst_n,
  input  logic lock_q,
  input  logic lock_d,
  input  logic gate,
  output logic clkout
);

  localparam int CW      = $clog2(DIV);
  localparam int HIGH_C  = (HIGH < 1) ? 1 : ((HIGH > DIV - 1) ? DIV - 1 : HIGH);
  localparam int PHASE_M = PHASE % DIV;
  localparam int INIT    = (DIV - PHASE_M) % DIV;

  localparam logic [CW-1:0] INIT_V = CW'(INIT);
  localparam logic [CW-1:0] LAST_V = CW'(DIV - 1);
  localparam logic [CW-1:0] HIGH_V = CW'(HIGH_C);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          gated_q, gated_d;

  // Counter parks at its phase-offset start value until lock, so the lock edge itself is count INIT.
  always_comb begin
    cnt_d   = INIT_V;
    gated_d = gated_q;
    if (lock_q) begin
      cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + 1'b1;
    end
    if (lock_d && (cnt_d == '0)) begin
      gated_d = gate;
    end
    out_d = lock_d & ~gated_d & (cnt_d < HIGH_V);
  end

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      out_q   <= 1'b0;
      gated_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      gated_q <= gated_d;
    end
  end

  assign clkout = out_q;

endmodule

module pll_clkdiv #(
  parameter int LOCK_CYCLES = 64,
  parameter int DIV0        = 2,
  parameter int DIV1        = 4,
  parameter int DIV2        = 8,
  parameter int HIGH0       = 1,
  parameter int HIGH1       = 2,
  parameter int HIGH2       = 4,
  parameter int PHASE0      = 0,
  parameter int PHASE1      = 0,
  parameter int PHASE2      = 0
) (
  input  logic clkin1,
  input  logic rst_n,
`ifdef PLL_CLKOUT_GATE_EN
  input  logic clkout0_gate,
  input  logic clkout1_gate,
  input  logic clkout2_gate,
`endif
  output logic clkout0,
  output logic clkout1,
  output logic clkout2,
  output logic pll_lock
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_V = LW'(LOCK_CYCLES);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_q, lock_d;
  logic [2:0]    gate;

`ifdef PLL_CLKOUT_GATE_EN
  assign gate = {clkout2_gate, clkout1_gate, clkout0_gate};
`else
  assign gate = 3'b000;
`endif

  // Lock rises on the edge the saturating counter reaches LOCK_CYCLES and stays up until reset.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (lock_cnt_q < LOCK_V) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
    lock_d = lock_q | (lock_cnt_d == LOCK_V);
  end

  always_ff @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= lock_d;
    end
  end

  assign pll_lock = lock_q;

  pll_clkdiv_chan #(.DIV(DIV0), .HIGH(HIGH0), .PHASE(PHASE0)) u_chan0 (
    .clkin1(clkin1), .rst_n(rst_n), .lock_q(lock_q), .lock_d(lock_d),
    .gate(gate[0]), .clkout(clkout0)
  );

  pll_clkdiv_chan #(.DIV(DIV1), .HIGH(HIGH1), .PHASE(PHASE1)) u_chan1 (
    .clkin1(clkin1), .rst_n(rst_n), .lock_q(lock_q), .lock_d(lock_d),
    .gate(gate[1]), .clkout(clkout1)
  );

  pll_clkdiv_chan #(.DIV(DIV2), .HIGH(HIGH2), .PHASE(PHASE2)) u_chan2 (
    .clkin1(clkin1), .rst_n(rst_n), .lock_q(lock_q), .lock_d(lock_d),
    .gate(gate[2]), .clkout(clkout2)
  );

endmodule

// File: tb/tb_pll_clkdiv.sv
// tb_pll_clkdiv: three differently parameterised pll_clkdiv instances checked every cycle against
// an arithmetic model (edges since reset release -> lock and output level), plus literal waveform pins.

module tb_pll_clkdiv;

  localparam int L = 64;

  logic clkin1;
  logic rst_n;
  logic g2;
  logic a0, a1, a2, a_lock;
  logic b0, b1, b2, b_lock;
  logic c0, c1, c2, c_lock;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  bit cmp_en = 0;
  bit gflag  = 0;

  int d_t[9] = '{2, 4, 8, 4, 5, 8, 3, 6, 8};
  int h_t[9] = '{1, 2, 4, 0, 2, 4, 3, 3, 4};
  int p_t[9] = '{0, 0, 0, 0, 3, 9, 0, 5, 0};

  // Hand-derived levels for the first 8 edges after lock, bit t = level after lock edge + t.
  logic [7:0] pat[9] = '{8'b01010101, 8'b00110011, 8'b00001111,
                         8'b00010001, 8'b00011000, 8'b00011110,
                         8'b11011011, 8'b11100011, 8'b00001111};

  pll_clkdiv dut_a (
    .clkin1(clkin1), .rst_n(rst_n),
`ifdef PLL_CLKOUT_GATE_EN
    .clkout0_gate(1'b0), .clkout1_gate(1'b0), .clkout2_gate(g2),
`endif
    .clkout0(a0), .clkout1(a1), .clkout2(a2), .pll_lock(a_lock)
  );

  pll_clkdiv #(.DIV0(4), .HIGH0(0), .DIV1(5), .HIGH1(2), .PHASE1(3),
               .DIV2(8), .HIGH2(4), .PHASE2(9)) dut_b (
    .clkin1(clkin1), .rst_n(rst_n),
`ifdef PLL_CLKOUT_GATE_EN
    .clkout0_gate(1'b0), .clkout1_gate(1'b0), .clkout2_gate(1'b0),
`endif
    .clkout0(b0), .clkout1(b1), .clkout2(b2), .pll_lock(b_lock)
  );

  pll_clkdiv #(.DIV0(3), .HIGH0(3), .DIV1(6), .HIGH1(3), .PHASE1(5)) dut_c (
    .clkin1(clkin1), .rst_n(rst_n),
`ifdef PLL_CLKOUT_GATE_EN
    .clkout0_gate(1'b0), .clkout1_gate(1'b0), .clkout2_gate(1'b0),
`endif
    .clkout0(c0), .clkout1(c1), .clkout2(c2), .pll_lock(c_lock)
  );

  initial begin
    clkin1 = 1'b0;
    forever #10 clkin1 = ~clkin1;
  end

  // Model time base: rising edges seen since the last reset release.
  always @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  // Gate on channel a2 is latched at the start of each 8-cycle period after lock.
  always @(posedge clkin1 or negedge rst_n) begin
    if (!rst_n) gflag <= 1'b0;
    else if ((edges + 1 >= L) && (((edges + 1 - L) % 8) == 0)) gflag <= g2;
  end

  function automatic logic exp_clk(input int e, input int d, input int h, input int p);
    int hc;
    int pm;
    int t;
    hc = (h < 1) ? 1 : ((h > d - 1) ? d - 1 : h);
    pm = p % d;
    if (e < L) return 1'b0;
    t = e - L;
    return ((((t - pm) % d) + d) % d) < hc;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  always @(negedge clkin1) begin
    if (cmp_en) begin
      logic [8:0] outs;
      logic       e_bit;
      outs = {c2, c1, c0, b2, b1, b0, a2, a1, a0};
      for (int i = 0; i < 9; i++) begin
        e_bit = exp_clk(edges, d_t[i], h_t[i], p_t[i]);
        if (i == 2) e_bit = e_bit & ~gflag;
        check_output($sformatf("model_clk%0d", i), {31'd0, outs[i]}, {31'd0, e_bit});
      end
      check_output("model_lock", {29'd0, a_lock, b_lock, c_lock},
                   (edges >= L) ? 32'd7 : 32'd0);
    end
  end

  task automatic wait_cycle();
    @(posedge clkin1);
    #5;
  endtask

  // Release reset, then pin the lock edge and the first eight post-lock levels literally.
  task automatic apply_stimulus();
    logic [8:0] outs;
    rst_n = 1'b1;
    repeat (L - 1) wait_cycle();
    check_output("prelock_lock", {31'd0, a_lock}, 32'd0);
    check_output("prelock_outs", {23'd0, c2, c1, c0, b2, b1, b0, a2, a1, a0}, 32'd0);
    for (int t = 0; t < 8; t++) begin
      wait_cycle();
      outs = {c2, c1, c0, b2, b1, b0, a2, a1, a0};
      if (t == 0) check_output("lock_edge", {29'd0, a_lock, b_lock, c_lock}, 32'd7);
      for (int i = 0; i < 9; i++) begin
        check_output($sformatf("pin_t%0d_clk%0d", t, i), {31'd0, outs[i]}, {31'd0, pat[i][t]});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    g2    = 1'b0;
    wait_cycle();
    cmp_en = 1'b1;
    wait_cycle();
    check_output("reset_state", {20'd0, a_lock, b_lock, c_lock, c2, c1, c0, b2, b1, b0, a2, a1, a0}, 32'd0);

    apply_stimulus();

    for (int n = 0; n < 2000; n++) begin
`ifdef PLL_CLKOUT_GATE_EN
      if ($urandom_range(0, 15) == 0) g2 = ~g2;
`endif
      wait_cycle();
      if (n == 1500) check_output("lock_sticky", {29'd0, a_lock, b_lock, c_lock}, 32'd7);
    end
    g2 = 1'b0;

    rst_n = 1'b0;
    #1;
    check_output("midrun_drop", {20'd0, a_lock, b_lock, c_lock, c2, c1, c0, b2, b1, b0, a2, a1, a0}, 32'd0);
    wait_cycle();
    apply_stimulus();

    for (int k = 0; k < 10; k++) begin
      int run;
      int hold;
      run  = $urandom_range(20, 200);
      hold = $urandom_range(1, 3);
      for (int n = 0; n < run; n++) begin
`ifdef PLL_CLKOUT_GATE_EN
        if ($urandom_range(0, 7) == 0) g2 = ~g2;
`endif
        wait_cycle();
      end
      rst_n = 1'b0;
      repeat (hold) wait_cycle();
      rst_n = 1'b1;
    end
    repeat (L + 20) wait_cycle();

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
